// File: rtl/transparency_unblend_channel.sv
// Per-channel transparency un-blender: recovers the smallest src_a consistent with a
// blended value, a known background and the src_a proportion, using a serial divider.
module transparency_unblend_channel #(
    parameter int TRANSPARENCY_PRECISION = 4,
    parameter int CHANNEL_WIDTH          = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNEL_WIDTH-1:0]        blended_in,
    input  logic [CHANNEL_WIDTH-1:0]        src_b_in,
    input  logic [TRANSPARENCY_PRECISION:0] src_a_proportion,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNEL_WIDTH-1:0]        src_a_out,
    output logic                            clamped,
    output logic                            undefined
);

    localparam int P    = TRANSPARENCY_PRECISION;
    localparam int CW   = CHANNEL_WIDTH;
    localparam int W    = P + CW + 3;
    localparam int CNTW = (CW > 1) ? $clog2(CW) : 1;

    localparam logic [P:0]    FULL_P   = {1'b1, {P{1'b0}}};
    localparam logic [P:0]    ZERO_P   = {(P+1){1'b0}};
    localparam logic [CW-1:0] ZERO_CW  = {CW{1'b0}};
    localparam logic [CW-1:0] MAX_CW   = {CW{1'b1}};
    localparam logic [CNTW-1:0] ZERO_CNT = {CNTW{1'b0}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREP     = 3'd1,
        CLASSIFY = 3'd2,
        DIV      = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       blend_q, blend_d;
    logic [CW-1:0]       srcb_q, srcb_d;
    logic [P:0]          prop_q, prop_d;
    logic signed [W-1:0] m_q, m_d;
    logic signed [W-1:0] n_q, n_d;
    logic [W-1:0]        rem_q, rem_d;
    logic [CW-1:0]       quot_q, quot_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]       src_a_q, src_a_d;
    logic                clamped_q, clamped_d;
    logic                undefined_q, undefined_d;
    logic                out_valid_q, out_valid_d;

    logic [P:0]          q_weight_s;
    logic [P+CW:0]       prod_s;
    logic signed [W-1:0] m_calc_s;
    logic signed [W-1:0] n_calc_s;
    logic signed [W-1:0] limit_s;
    logic [W-1:0]        div_shift_s;
    logic                bit_fits_s;

    // M is registered before classification so the multiply and the compares sit in separate cycles.
    assign q_weight_s  = FULL_P - prop_q;
    assign prod_s      = q_weight_s * srcb_q;
    assign m_calc_s    = $signed({{(W-CW-P){1'b0}}, blend_q, {P{1'b0}}})
                       - $signed({{(W-P-CW-1){1'b0}}, prod_s});
    assign n_calc_s    = m_calc_s + $signed({{(W-P-1){1'b0}}, prop_q})
                       - $signed({{(W-1){1'b0}}, 1'b1});
    assign limit_s     = $signed({{(W-P-CW-1){1'b0}}, prop_q, {CW{1'b0}}});
    assign div_shift_s = {{(W-P-1){1'b0}}, prop_q} << cnt_q;
    assign bit_fits_s  = (rem_q >= div_shift_s);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign src_a_out = src_a_q;
    assign clamped   = clamped_q;
    assign undefined = undefined_q;

    // Next-state logic for the control FSM, divider datapath and result registers.
    always_comb begin
        state_d     = state_q;
        blend_d     = blend_q;
        srcb_d      = srcb_q;
        prop_d      = prop_q;
        m_d         = m_q;
        n_d         = n_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        cnt_d       = cnt_q;
        src_a_d     = src_a_q;
        clamped_d   = clamped_q;
        undefined_d = undefined_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    blend_d = blended_in;
                    srcb_d  = src_b_in;
                    prop_d  = src_a_proportion;
                    state_d = PREP;
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                m_d     = m_calc_s;
                n_d     = n_calc_s;
                state_d = CLASSIFY;
            end
            CLASSIFY: begin
                // An out-of-range proportion carries no usable weight, same as zero.
                if ((prop_q == ZERO_P) || (prop_q > FULL_P)) begin
                    src_a_d     = ZERO_CW;
                    clamped_d   = 1'b0;
                    undefined_d = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (m_q < $signed({W{1'b0}})) begin
                    src_a_d     = ZERO_CW;
                    clamped_d   = 1'b1;
                    undefined_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else if (n_q >= limit_s) begin
                    src_a_d     = MAX_CW;
                    clamped_d   = 1'b1;
                    undefined_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    rem_d   = n_q;
                    quot_d  = ZERO_CW;
                    cnt_d   = CNTW'(CW - 1);
                    state_d = DIV;
                end
            end
            DIV: begin
                if (bit_fits_s) begin
                    rem_d = rem_q - div_shift_s;
                end else begin
                    rem_d = rem_q;
                end
                quot_d[cnt_q] = bit_fits_s;
                if (cnt_q == ZERO_CNT) begin
                    src_a_d     = quot_d;
                    clamped_d   = 1'b0;
                    undefined_d = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d   = cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
                    state_d = DIV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            blend_q     <= ZERO_CW;
            srcb_q      <= ZERO_CW;
            prop_q      <= ZERO_P;
            m_q         <= {W{1'b0}};
            n_q         <= {W{1'b0}};
            rem_q       <= {W{1'b0}};
            quot_q      <= ZERO_CW;
            cnt_q       <= ZERO_CNT;
            src_a_q     <= ZERO_CW;
            clamped_q   <= 1'b0;
            undefined_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blend_q     <= blend_d;
            srcb_q      <= srcb_d;
            prop_q      <= prop_d;
            m_q         <= m_d;
            n_q         <= n_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            cnt_q       <= cnt_d;
            src_a_q     <= src_a_d;
            clamped_q   <= clamped_d;
            undefined_q <= undefined_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_transparency_unblend_channel.sv
// Directed, table-driven bench for transparency_unblend_channel with hand-computed
// results, plus backpressure and mid-divide reset sequences.
module tb_transparency_unblend_channel;

    localparam int P         = 4;
    localparam int CW        = 8;
    localparam int DIV_LAT   = CW + 2;
    localparam int SHORT_LAT = 2;
    localparam int NVEC      = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] blended_in;
    logic [CW-1:0] src_b_in;
    logic [P:0]    src_a_proportion;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] src_a_out;
    logic          clamped;
    logic          undefined;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [CW-1:0] bl;
        logic [CW-1:0] sb;
        logic [P:0]    p;
        logic [CW-1:0] exp_a;
        logic          exp_c;
        logic          exp_u;
        int            exp_lat;
    } vec_t;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    transparency_unblend_channel #(
        .TRANSPARENCY_PRECISION(P),
        .CHANNEL_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .blended_in(blended_in),
        .src_b_in(src_b_in),
        .src_a_proportion(src_a_proportion),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .src_a_out(src_a_out),
        .clamped(clamped),
        .undefined(undefined)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Accept one operand set, scramble inputs while busy, wait for out_valid.
    task automatic issue(input logic [CW-1:0] bl, input logic [CW-1:0] sb,
                         input logic [P:0] p, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid         = 1'b1;
        blended_in       = bl;
        src_b_in         = sb;
        src_a_proportion = p;
        @(posedge clk);
        @(negedge clk);
        blended_in       = ~bl;
        src_b_in         = ~sb;
        src_a_proportion = 5'd3;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
    endtask

    // Complete the output handshake from the current negedge.
    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_handshake", {31'd0, out_valid}, 32'd0);
        check("in_ready_after_handshake", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int fwd;
        logic [CW-1:0] held_a;

        vecs[0]  = '{8'd200, 8'd37,  5'd16, 8'd200, 1'b0, 1'b0, DIV_LAT};
        vecs[1]  = '{8'd146, 8'd92,  5'd8,  8'd200, 1'b0, 1'b0, DIV_LAT};
        vecs[2]  = '{8'd77,  8'd190, 5'd0,  8'd0,   1'b0, 1'b1, SHORT_LAT};
        vecs[3]  = '{8'd0,   8'd255, 5'd4,  8'd0,   1'b1, 1'b0, SHORT_LAT};
        vecs[4]  = '{8'd255, 8'd0,   5'd1,  8'd255, 1'b1, 1'b0, SHORT_LAT};
        vecs[5]  = '{8'd50,  8'd60,  5'd17, 8'd0,   1'b0, 1'b1, SHORT_LAT};
        vecs[6]  = '{8'd100, 8'd50,  5'd12, 8'd117, 1'b0, 1'b0, DIV_LAT};
        vecs[7]  = '{8'd0,   8'd255, 5'd16, 8'd0,   1'b0, 1'b0, DIV_LAT};
        vecs[8]  = '{8'd255, 8'd0,   5'd16, 8'd255, 1'b0, 1'b0, DIV_LAT};
        vecs[9]  = '{8'd30,  8'd15,  5'd1,  8'd255, 1'b0, 1'b0, DIV_LAT};
        vecs[10] = '{8'd16,  8'd0,   5'd1,  8'd255, 1'b1, 1'b0, SHORT_LAT};
        vecs[11] = '{8'd10,  8'd10,  5'd2,  8'd10,  1'b0, 1'b0, DIV_LAT};
        vecs[12] = '{8'd0,   8'd1,   5'd8,  8'd0,   1'b1, 1'b0, SHORT_LAT};
        vecs[13] = '{8'd5,   8'd10,  5'd8,  8'd0,   1'b0, 1'b0, DIV_LAT};

        rst              = 1'b1;
        in_valid         = 1'b0;
        out_ready        = 1'b0;
        blended_in       = 8'd0;
        src_b_in         = 8'd0;
        src_a_proportion = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_src_a", {24'd0, src_a_out}, 32'd0);
        check("reset_clamped", {31'd0, clamped}, 32'd0);
        check("reset_undefined", {31'd0, undefined}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].bl, vecs[i].sb, vecs[i].p, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_src_a", i), {24'd0, src_a_out}, {24'd0, vecs[i].exp_a});
            check($sformatf("vec%0d_clamped", i), {31'd0, clamped}, {31'd0, vecs[i].exp_c});
            check($sformatf("vec%0d_undefined", i), {31'd0, undefined}, {31'd0, vecs[i].exp_u});
            if (!vecs[i].exp_c && !vecs[i].exp_u) begin
                fwd = (int'(src_a_out) * int'(vecs[i].p)
                       + int'(vecs[i].sb) * (16 - int'(vecs[i].p))) >> P;
                check($sformatf("vec%0d_reblend", i), fwd, {24'd0, vecs[i].bl});
            end
            release_out();
        end

        // Backpressure: result and flags held while out_ready is low.
        issue(8'd146, 8'd92, 5'd8, lat);
        check("bp_latency", lat, DIV_LAT);
        held_a = src_a_out;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_src_a", {24'd0, src_a_out}, 32'd200);
            check("bp_src_a_stable", {24'd0, src_a_out}, {24'd0, held_a});
            check("bp_flags", {30'd0, clamped, undefined}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        release_out();
        @(negedge clk);
        check("bp_single_handshake", {31'd0, out_valid}, 32'd0);

        // Reset during the third divide cycle aborts the operation.
        @(negedge clk);
        in_valid         = 1'b1;
        blended_in       = 8'd200;
        src_b_in         = 8'd37;
        src_a_proportion = 5'd16;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_src_a", {24'd0, src_a_out}, 32'd0);
        issue(8'd100, 8'd50, 5'd12, lat);
        check("post_rst_latency", lat, DIV_LAT);
        check("post_rst_src_a", {24'd0, src_a_out}, 32'd117);
        check("post_rst_flags", {30'd0, clamped, undefined}, 32'd0);
        release_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/transparency_unblend_channel.md
Name: transparency_unblend_channel

Overview:
- Inverse of the per-channel transparency blender: given a blended channel value, the known background (src_b) value and the src_a proportion, recovers the smallest src_a value consistent with the blend.
- Sits in the pipeline calibration/overlay-extraction path, one instance per colour channel.
- Uses an iterative restoring divider behind a valid/ready handshake, so throughput is one result per divide.

Parameters:
- TRANSPARENCY_PRECISION, 4, proportion fraction bits; full weight is 2^TRANSPARENCY_PRECISION.
- CHANNEL_WIDTH, 8, bits per colour channel.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept operands.
- blended_in  in  CHANNEL_WIDTH  blended channel value.
- src_b_in  in  CHANNEL_WIDTH  background channel value.
- src_a_proportion  in  TRANSPARENCY_PRECISION+1  weight of src_a; legal range 0..2^TRANSPARENCY_PRECISION.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- src_a_out  out  CHANNEL_WIDTH  recovered src_a value.
- clamped  out  1  result saturated to 0 or to the maximum.
- undefined  out  1  proportion was 0, so src_a is unrecoverable.

Behaviour:
- Reset values: in_ready=1, out_valid=0, src_a_out=0, clamped=0, undefined=0, state=IDLE. Reset takes priority in any state and aborts any divide in progress; the partial result is discarded.
- Notation: P=TRANSPARENCY_PRECISION, CW=CHANNEL_WIDTH, p=proportion, q=2^P-p.
- Arithmetic, computed in signed P+CW+3 bits:
  - M = blended<<P − q*src_b.
  - N = M + p − 1.
  - Result = floor(N/p), which equals ceil(M/p).
  - With p=2^P the result must equal blended_in exactly.
- Operand capture: operands are registered on the edge where in_valid && in_ready. in_ready = (state==IDLE), driven combinationally from the registered state.
- IDLE: on accept, go to PREP.
- PREP, 1 cycle: compute M and N, then classify:
  - p==0: src_a_out=0, undefined=1, clamped=0; go to DONE.
  - p>2^P (illegal): treat as p==0.
  - M<0: src_a_out=0, clamped=1; go to DONE.
  - N ≥ p<<CW: src_a_out=2^CW−1, clamped=1; go to DONE.
  - Otherwise: load the divider (remainder=0, dividend=N, bit counter=CW−1); go to DIV.
- DIV, exactly CW cycles:
  - Restoring division, MSB-first, one quotient bit per cycle.
  - The quotient is guaranteed < 2^CW by the PREP check.
  - After the final bit: src_a_out=quotient, flags=0; go to DONE.
- DONE:
  - out_valid=1; src_a_out and flags are held stable until out_valid && out_ready.
  - On handshake go to IDLE, with out_valid=0 on the next cycle.
- Latency, counted from the accept edge k:
  - Divided result: out_valid first high in the cycle after edge k+CW+2.
  - Short-circuit result: out_valid first high in the cycle after edge k+2.
- Throughput: the next accept can occur at the earliest one cycle after the output handshake. There is no overlap of input and output.
- src_a_out and the flags change only on entry to DONE. Outside DONE they hold their last values and must be ignored.
- Changes on in_valid or the operand inputs while not in IDLE are ignored.

Test Plan:
- P=4, CW=8, p=16, blended=200, src_b=37 -> src_a_out=200, flags 0, out_valid 10 cycles after accept.
- p=8, blended=146, src_b=92 -> M=1600, N=1607, src_a_out=200, flags 0; feeding 200/92 back through the forward blender reproduces 146.
- p=0, any blended/src_b -> src_a_out=0, undefined=1, clamped=0, out_valid 2 cycles after accept.
- Clamping:
  - p=4, blended=0, src_b=255 -> M=−3060, src_a_out=0, clamped=1.
  - p=1, blended=255, src_b=0 -> N=4080 ≥ 256, src_a_out=255, clamped=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, src_a_out and flags stable, in_ready=0; on release there is one handshake, and in_ready=1 the next cycle.
- Reset mid-operation: assert rst during DIV cycle 3 -> the next cycle shows out_valid=0 and in_ready=1; a fresh operation afterwards returns the correct result.
